// File: rtl/rifl_pkg.sv
// Shared frame definitions for the RIFL lane transmit and receive paths:
// meta codes and the bit offsets of each frame field.
package rifl_pkg;

    typedef enum logic [1:0] {
        META_IDLE    = 2'b00,
        META_DATA    = 2'b01,
        META_EOP_ABV = 2'b10,
        META_EOP     = 2'b11
    } meta_e;

    localparam int HDR_W      = 2;
    localparam int META_W     = 2;
    localparam int HDR_META_W = HDR_W + META_W;
    localparam int BYTE_W     = 8;

    // Field positions are all measured down from the frame MSB.
    function automatic int hdr_msb(input int fw);
        return fw - 1;
    endfunction

    function automatic int meta_msb(input int fw);
        return fw - 1 - HDR_W;
    endfunction

    function automatic int payload_msb(input int fw);
        return fw - 1 - HDR_META_W;
    endfunction

    function automatic int payload_lsb(input int fw, input int pw);
        return fw - HDR_META_W - pw;
    endfunction

endpackage

// File: rtl/tx_dwidth_conv_if.sv
// Payload stream and lane beat signals between the packet source, the
// width converter and the serial lane.
interface tx_dwidth_conv_if #(
    parameter int DWIDTH        = 64,
    parameter int PAYLOAD_WIDTH = 240
);
    localparam int TK = PAYLOAD_WIDTH / 8;

    logic [PAYLOAD_WIDTH-1:0] int_tdata;
    logic [TK-1:0]            int_tkeep;
    logic                     int_tlast;
    logic                     int_tvalid;
    logic                     int_tready;
    logic                     beat_en;
    logic [DWIDTH-1:0]        dout;
    logic                     data_sof;

    modport master (
        output int_tdata, int_tkeep, int_tlast, int_tvalid, beat_en,
        input  int_tready, dout, data_sof
    );

    modport slave (
        input  int_tdata, int_tkeep, int_tlast, int_tvalid, beat_en,
        output int_tready, dout, data_sof
    );

endinterface

// File: rtl/tx_frame_encode.sv
// Combinational frame builder: header, meta code, payload (with byte count
// substituted on a partial last beat) and a zeroed CRC field.
module tx_frame_encode
    import rifl_pkg::*;
#(
    parameter int         FRAME_WIDTH   = 256,
    parameter int         PAYLOAD_WIDTH = 240,
    parameter logic [1:0] DATA_HDR      = 2'b01
) (
    input  logic [PAYLOAD_WIDTH-1:0]   i_tdata,
    input  logic [PAYLOAD_WIDTH/8-1:0] i_tkeep,
    input  logic                       i_tlast,
    input  logic                       i_tvalid,
    output logic [FRAME_WIDTH-1:0]     o_frame
);
    localparam int TK       = PAYLOAD_WIDTH / 8;
    localparam int HDR_MSB  = hdr_msb(FRAME_WIDTH);
    localparam int META_MSB = meta_msb(FRAME_WIDTH);
    localparam int PAY_MSB  = payload_msb(FRAME_WIDTH);

    logic [BYTE_W-1:0]        w_keep_cnt;
    meta_e                    w_meta;
    logic [PAYLOAD_WIDTH-1:0] w_payload;

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < TK; i++) begin
            w_keep_cnt = w_keep_cnt + {{(BYTE_W-1){1'b0}}, i_tkeep[i]};
        end
    end

    // A partial last beat reuses its final byte slot to carry the valid byte count.
    always_comb begin
        w_meta    = META_IDLE;
        w_payload = '0;
        if (i_tvalid) begin
            w_payload = i_tdata;
            if (!i_tlast) begin
                w_meta = META_DATA;
            end else if (&i_tkeep) begin
                w_meta = META_EOP;
            end else begin
                w_meta = META_EOP_ABV;
                w_payload[BYTE_W-1:0] = w_keep_cnt;
            end
        end
    end

    always_comb begin
        o_frame                             = '0;
        o_frame[HDR_MSB  -: HDR_W]          = DATA_HDR;
        o_frame[META_MSB -: META_W]         = w_meta;
        o_frame[PAY_MSB  -: PAYLOAD_WIDTH]  = w_payload;
    end

endmodule

// File: rtl/tx_dwidth_conv.sv
// Transmit width converter: encodes one payload per frame and serialises the
// frame onto the lane one DWIDTH beat per beat_en, MSB slice first.
module tx_dwidth_conv
    import rifl_pkg::*;
#(
    parameter int         DWIDTH        = 64,
    parameter int         FRAME_WIDTH   = 256,
    parameter int         PAYLOAD_WIDTH = 240,
    parameter logic [1:0] DATA_HDR      = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    tx_dwidth_conv_if.slave bus
);
    localparam int RATIO = FRAME_WIDTH / DWIDTH;

    logic [FRAME_WIDTH-1:0] w_frame;
    logic                   w_boundary;
    logic                   w_tready;
    logic [DWIDTH-1:0]      r_dout_p1;
    logic                   r_sof_p1;

    tx_frame_encode #(
        .FRAME_WIDTH   (FRAME_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .DATA_HDR      (DATA_HDR)
    ) u_encode (
        .i_tdata  (bus.int_tdata),
        .i_tkeep  (bus.int_tkeep),
        .i_tlast  (bus.int_tlast),
        .i_tvalid (bus.int_tvalid),
        .o_frame  (w_frame)
    );

    // A frame is taken only on the beat that emits its first slice, so idle
    // frames fill the lane whenever no payload is waiting at a boundary.
    assign w_tready       = bus.beat_en & w_boundary & ~rst;
    assign bus.int_tready = w_tready;
    assign bus.dout       = r_dout_p1;
    assign bus.data_sof   = r_sof_p1;

    generate
        if (RATIO == 1) begin : g_ratio1
            assign w_boundary = 1'b1;

            // stage p1: whole frame registered onto the lane every beat
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout_p1 <= '0;
                    r_sof_p1  <= 1'b0;
                end else if (bus.beat_en) begin
                    r_dout_p1 <= w_frame;
                    r_sof_p1  <= 1'b1;
                end
            end
        end else begin : g_ratio_n
            localparam int CW = $clog2(RATIO);

            logic [CW-1:0]          r_cnt;
            logic [FRAME_WIDTH-1:0] r_sreg;

            assign w_boundary = (r_cnt == '0);

            // stage p1: slice 0 comes straight from the encoder; the remaining
            // slices are parked in r_sreg and shifted up one beat at a time.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt     <= '0;
                    r_sreg    <= '0;
                    r_dout_p1 <= '0;
                    r_sof_p1  <= 1'b0;
                end else if (bus.beat_en) begin
                    r_cnt    <= r_cnt + CW'(1);
                    r_sof_p1 <= w_boundary;
                    if (w_boundary) begin
                        r_dout_p1 <= w_frame[FRAME_WIDTH-1 -: DWIDTH];
                        r_sreg    <= w_frame << DWIDTH;
                    end else begin
                        r_dout_p1 <= r_sreg[FRAME_WIDTH-1 -: DWIDTH];
                        r_sreg    <= r_sreg << DWIDTH;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_tx_dwidth_conv.sv
// Scoreboard bench for tx_dwidth_conv: a frame-level model queues expected
// lane beats and a separate monitor compares every beat the DUT emits.
module tb_tx_dwidth_conv;
    localparam int         DW    = 64;
    localparam int         FW    = 256;
    localparam int         PW    = 240;
    localparam int         TK    = PW / 8;
    localparam int         ZW    = FW - 4 - PW;
    localparam int         RATIO = FW / DW;
    localparam logic [1:0] HDR   = 2'b01;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_dwidth_conv_if #(.DWIDTH(DW), .PAYLOAD_WIDTH(PW)) bus ();

    tx_dwidth_conv #(
        .DWIDTH        (DW),
        .FRAME_WIDTH   (FW),
        .PAYLOAD_WIDTH (PW),
        .DATA_HDR      (HDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t          exp_q[$];
    int             checks = 0;
    int             errors = 0;
    int             pos    = 0;
    int             sent   = 0;
    logic [PW-1:0]  cur_data;
    logic [TK-1:0]  cur_keep;
    logic           cur_last;
    logic           have_pkt = 1'b0;
    logic           auto_pkt = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame contents derived directly from the field rules.
    function automatic logic [FW-1:0] model_frame(input logic v, input logic [PW-1:0] d,
                                                  input logic [TK-1:0] k, input logic l);
        logic [1:0]    meta;
        logic [PW-1:0] p;
        int            n;
        if (!v) return {HDR, 2'b00, {PW{1'b0}}, {ZW{1'b0}}};
        p = d;
        n = $countones(k);
        if (!l)          meta = 2'b01;
        else if (n == TK) meta = 2'b11;
        else begin
            meta   = 2'b10;
            p[7:0] = 8'(n);
        end
        return {HDR, meta, p, {ZW{1'b0}}};
    endfunction

    task automatic rand_pkt();
        logic [255:0] t;
        int           n;
        for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
        cur_data = t[PW-1:0];
        cur_last = ($urandom_range(0, 3) == 0);
        if (cur_last) begin
            n        = $urandom_range(1, TK);
            cur_keep = {TK{1'b1}} << (TK - n);
        end else begin
            cur_keep = TK'($urandom);
        end
        have_pkt = 1'b1;
    endtask

    task automatic set_pkt(input logic [PW-1:0] d, input logic [TK-1:0] k, input logic l);
        cur_data = d;
        cur_keep = k;
        cur_last = l;
        have_pkt = 1'b1;
    endtask

    task automatic cycle(input logic en, input logic rst_v, input logic drop);
        logic          vld;
        logic          exp_rdy;
        logic [FW-1:0] f;
        @(negedge clk);
        vld            = have_pkt && !drop;
        rst            = rst_v;
        bus.beat_en    = en;
        bus.int_tvalid = vld;
        bus.int_tdata  = cur_data;
        bus.int_tkeep  = cur_keep;
        bus.int_tlast  = cur_last;
        #1;
        exp_rdy = en && (pos == 0) && !rst_v;
        check("int_tready", {63'd0, bus.int_tready}, {63'd0, exp_rdy});
        if (rst_v) begin
            exp_q.delete();
            pos = 0;
        end else if (en) begin
            if (pos == 0) begin
                f = model_frame(vld, cur_data, cur_keep, cur_last);
                for (int i = 0; i < RATIO; i++) exp_q.push_back('{f[FW-1-i*DW -: DW], i == 0});
                if (vld) begin
                    sent++;
                    if (auto_pkt) rand_pkt();
                    else          have_pkt = 1'b0;
                end
            end
            pos = (pos + 1) % RATIO;
        end
    endtask

    task automatic run_until_sent(input int target);
        for (int i = 0; i < 32 && sent < target; i++) cycle(1'b1, 1'b0, 1'b0);
        check("payload_accepted", 64'(sent), 64'(target));
    endtask

    initial begin : monitor
        beat_t e;
        beat_t last;
        logic  en_q;
        logic  rst_q;
        last = '0;
        forever begin
            @(posedge clk);
            en_q  = bus.beat_en;
            rst_q = rst;
            #1;
            if (rst_q) begin
                check("reset_dout", bus.dout, '0);
                check("reset_sof", {63'd0, bus.data_sof}, 64'd0);
                last = '0;
            end else if (en_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h with nothing expected", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", bus.dout, e.d);
                    check("data_sof", {63'd0, bus.data_sof}, {63'd0, e.sof});
                    last = e;
                end
            end else begin
                check("hold_dout", bus.dout, last.d);
                check("hold_sof", {63'd0, bus.data_sof}, {63'd0, last.sof});
            end
        end
    end

    initial begin : driver
        int base;
        bus.beat_en    = 1'b0;
        bus.int_tvalid = 1'b0;
        bus.int_tdata  = '0;
        bus.int_tkeep  = '0;
        bus.int_tlast  = 1'b0;
        cur_data = '0;
        cur_keep = '0;
        cur_last = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);

        set_pkt({TK{8'hAA}}, TK'($urandom), 1'b0);
        run_until_sent(1);
        set_pkt({TK{8'h5C}}, {TK{1'b1}}, 1'b1);
        run_until_sent(2);
        set_pkt({TK{8'h3D}}, 30'h3E000000, 1'b1);
        run_until_sent(3);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);

        auto_pkt = 1'b1;
        rand_pkt();
        for (int i = 0; i < 64; i++) cycle(i[0] == 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16 && pos != 0; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);

        base = sent;
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0);
        checks++;
        if (sent - base < 50) begin
            errors++;
            $display("FAIL random_throughput: got %0d packets, expected at least 50", sent - base);
        end

        auto_pkt = 1'b0;
        have_pkt = 1'b0;
        for (int i = 0; i < 16 && pos != 0; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
